// File: rtl/transporter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : transporter_pkg
// Description : Shared FSM state types and frame-header helpers for the
//               byte link arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package transporter_pkg;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_HDR  = 2'd1,
        TX_PAY  = 2'd2,
        TX_DONE = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_HDR = 2'd0,
        RX_PAY = 2'd1,
        RX_DLV = 2'd2
    } rx_state_t;

    localparam logic [7:0] HDR_MARK = 8'h80;

    function automatic logic [7:0] make_hdr(input logic [2:0] id);
        return HDR_MARK | {5'b0, id};
    endfunction

    // ID < n already implies the unused ID bits in [2:0] are zero, since n <= 2**ID_W
    function automatic logic hdr_valid(input logic [7:0] b, input int n);
        return b[7] && (b[6:3] == 4'b0) && (int'(b[2:0]) < n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter; grants the first requester
//               at or after the pointer, wrapping, as one-hot plus binary ID.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    i_req,
    input  logic [ID_W-1:0] i_ptr,
    output logic [N-1:0]    o_gnt,
    output logic [ID_W-1:0] o_gnt_id
);

    localparam int IW = ID_W + 1;

    logic [IW-1:0] w_idx;
    logic          w_found;

    always_comb begin
        o_gnt    = '0;
        o_gnt_id = '0;
        w_found  = 1'b0;
        w_idx    = '0;
        for (int i = 0; i < N; i++) begin
            // one extra bit lets ptr+i exceed N before the modular wrap
            w_idx = {1'b0, i_ptr} + IW'(i);
            if (w_idx >= IW'(N)) begin
                w_idx = w_idx - IW'(N);
            end
            if (!w_found && i_req[w_idx[ID_W-1:0]]) begin
                w_found                 = 1'b1;
                o_gnt[w_idx[ID_W-1:0]]  = 1'b1;
                o_gnt_id                = w_idx[ID_W-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/byte_link_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : byte_link_arbiter
// Description : Shares one serdes byte port among N_CLIENTS clients using
//               2-byte (header+payload) frames; independent TX and RX FSMs.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_link_arbiter
    import transporter_pkg::*;
#(
    parameter int N_CLIENTS = 4,
    parameter int ID_W      = $clog2(N_CLIENTS),
    parameter int ERR_W     = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_CLIENTS*8-1:0] cl_tx_data,
    input  logic [N_CLIENTS-1:0]   cl_tx_req,
    output logic [N_CLIENTS-1:0]   cl_tx_acc,
    output logic [N_CLIENTS*8-1:0] cl_rx_data,
    output logic [N_CLIENTS-1:0]   cl_rx_req,
    input  logic [N_CLIENTS-1:0]   cl_rx_acc,
    output logic                   sd_tx_req,
    output logic [7:0]             sd_tx_data,
    input  logic                   sd_tx_gnt,
    input  logic                   sd_rx_req,
    input  logic [7:0]             sd_rx_data,
    output logic                   sd_rx_gnt,
    output logic                   err_hdr,
    output logic [ERR_W-1:0]       err_cnt
);

    localparam logic [ID_W-1:0] c_last_id = ID_W'(N_CLIENTS - 1);

    tx_state_t             r_tx_state, w_tx_state_nxt;
    logic [ID_W-1:0]       r_tx_id, r_rr_ptr, w_arb_id;
    logic [N_CLIENTS-1:0]  w_arb_gnt;
    logic [7:0]            r_tx_pay, w_arb_data;

    rx_state_t             r_rx_state, w_rx_state_nxt;
    logic [ID_W-1:0]       r_rx_id;
    logic [7:0]            r_rx_pay;
    logic                  r_err_hdr, w_hdr_ok;
    logic [ERR_W-1:0]      r_err_cnt;

    rr_arbiter #(.N(N_CLIENTS), .ID_W(ID_W)) u_rr_arbiter (
        .i_req    (cl_tx_req),
        .i_ptr    (r_rr_ptr),
        .o_gnt    (w_arb_gnt),
        .o_gnt_id (w_arb_id)
    );

    always_comb begin
        w_arb_data = '0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            if (w_arb_gnt[i]) begin
                w_arb_data = w_arb_data | cl_tx_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        sd_tx_req      = 1'b0;
        sd_tx_data     = '0;
        cl_tx_acc      = '0;
        case (r_tx_state)
            TX_IDLE: if (|cl_tx_req) w_tx_state_nxt = TX_HDR;
            TX_HDR: begin
                sd_tx_req  = 1'b1;
                sd_tx_data = make_hdr(3'(r_tx_id));
                if (sd_tx_gnt) w_tx_state_nxt = TX_PAY;
            end
            TX_PAY: begin
                sd_tx_req  = 1'b1;
                sd_tx_data = r_tx_pay;
                if (sd_tx_gnt) w_tx_state_nxt = TX_DONE;
            end
            TX_DONE: begin
                cl_tx_acc[r_tx_id] = 1'b1;
                w_tx_state_nxt     = TX_IDLE;
            end
            default: w_tx_state_nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_state <= TX_IDLE;
            r_tx_id    <= '0;
            r_tx_pay   <= '0;
            r_rr_ptr   <= '0;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            if (r_tx_state == TX_IDLE && |cl_tx_req) begin
                r_tx_id  <= w_arb_id;
                r_tx_pay <= w_arb_data;
            end
            if (r_tx_state == TX_DONE) begin
                r_rr_ptr <= (r_tx_id == c_last_id) ? '0 : r_tx_id + ID_W'(1);
            end
        end
    end

    assign w_hdr_ok = hdr_valid(sd_rx_data, N_CLIENTS);

    // Delivery stalls the serdes side: no RX byte is taken while a payload waits
    always_comb begin
        w_rx_state_nxt = r_rx_state;
        sd_rx_gnt      = 1'b0;
        cl_rx_req      = '0;
        cl_rx_data     = '0;
        case (r_rx_state)
            RX_HDR: begin
                sd_rx_gnt = sd_rx_req;
                if (sd_rx_req && w_hdr_ok) w_rx_state_nxt = RX_PAY;
            end
            RX_PAY: begin
                sd_rx_gnt = sd_rx_req;
                if (sd_rx_req) w_rx_state_nxt = RX_DLV;
            end
            RX_DLV: begin
                cl_rx_req[r_rx_id] = 1'b1;
                cl_rx_data         = {N_CLIENTS{r_rx_pay}};
                if (cl_rx_acc[r_rx_id]) w_rx_state_nxt = RX_HDR;
            end
            default: w_rx_state_nxt = RX_HDR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_state <= RX_HDR;
            r_rx_id    <= '0;
            r_rx_pay   <= '0;
            r_err_hdr  <= 1'b0;
            r_err_cnt  <= '0;
        end else begin
            r_rx_state <= w_rx_state_nxt;
            r_err_hdr  <= (r_rx_state == RX_HDR) && sd_rx_req && !w_hdr_ok;
            if (r_rx_state == RX_HDR && sd_rx_req) begin
                if (w_hdr_ok) begin
                    r_rx_id <= sd_rx_data[ID_W-1:0];
                end else if (r_err_cnt != '1) begin
                    r_err_cnt <= r_err_cnt + ERR_W'(1);
                end
            end
            if (r_rx_state == RX_PAY && sd_rx_req) begin
                r_rx_pay <= sd_rx_data;
            end
        end
    end

    assign err_hdr = r_err_hdr;
    assign err_cnt = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_byte_link_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_byte_link_arbiter
// Description : Directed scoreboard bench for byte_link_arbiter (N_CLIENTS=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_byte_link_arbiter;

    logic        clk;
    logic        rst_n;
    logic [31:0] cl_tx_data;
    logic [3:0]  cl_tx_req;
    logic [3:0]  cl_tx_acc;
    logic [31:0] cl_rx_data;
    logic [3:0]  cl_rx_req;
    logic [3:0]  cl_rx_acc;
    logic        sd_tx_req;
    logic [7:0]  sd_tx_data;
    logic        sd_tx_gnt;
    logic        sd_rx_req;
    logic [7:0]  sd_rx_data;
    logic        sd_rx_gnt;
    logic        err_hdr;
    logic [7:0]  err_cnt;

    int checks = 0;
    int errors = 0;
    int err_seen = 0;

    logic [7:0] tx_exp[$];
    logic [3:0] acc_exp[$];
    logic [3:0] rxr_exp[$];
    logic [7:0] rxd_exp[$];

    byte_link_arbiter #(.N_CLIENTS(4), .ERR_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cl_tx_data (cl_tx_data),
        .cl_tx_req  (cl_tx_req),
        .cl_tx_acc  (cl_tx_acc),
        .cl_rx_data (cl_rx_data),
        .cl_rx_req  (cl_rx_req),
        .cl_rx_acc  (cl_rx_acc),
        .sd_tx_req  (sd_tx_req),
        .sd_tx_data (sd_tx_data),
        .sd_tx_gnt  (sd_tx_gnt),
        .sd_rx_req  (sd_rx_req),
        .sd_rx_data (sd_rx_data),
        .sd_rx_gnt  (sd_rx_gnt),
        .err_hdr    (err_hdr),
        .err_cnt    (err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs_zero(input string pfx);
        check({pfx, "_sd_tx_req"},  32'(sd_tx_req),  32'd0);
        check({pfx, "_sd_tx_data"}, 32'(sd_tx_data), 32'd0);
        check({pfx, "_cl_tx_acc"},  32'(cl_tx_acc),  32'd0);
        check({pfx, "_cl_rx_req"},  32'(cl_rx_req),  32'd0);
        check({pfx, "_cl_rx_data"}, cl_rx_data,      32'd0);
        check({pfx, "_sd_rx_gnt"},  32'(sd_rx_gnt),  32'd0);
        check({pfx, "_err_hdr"},    32'(err_hdr),    32'd0);
        check({pfx, "_err_cnt"},    32'(err_cnt),    32'd0);
    endtask

    // Scoreboard: pops expectations whenever the DUT completes a transfer
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (sd_tx_req && sd_tx_gnt) begin
                if (tx_exp.size() == 0) check("tx_byte_unexpected", 32'(sd_tx_data), 32'h100);
                else check("tx_byte", 32'(sd_tx_data), 32'(tx_exp.pop_front()));
            end
            if (|cl_tx_acc) begin
                if (acc_exp.size() == 0) check("tx_acc_unexpected", 32'(cl_tx_acc), 32'd0);
                else check("tx_acc", 32'(cl_tx_acc), 32'(acc_exp.pop_front()));
            end
            if (|(cl_rx_req & cl_rx_acc)) begin
                if (rxr_exp.size() == 0) check("rx_unexpected", 32'(cl_rx_req), 32'd0);
                else begin
                    check("rx_req", 32'(cl_rx_req), 32'(rxr_exp.pop_front()));
                    check("rx_data", cl_rx_data, {4{rxd_exp.pop_front()}});
                end
            end
            if (err_hdr) err_seen++;
        end
    endtask

    task automatic wait_tx_req();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sd_tx_req && n < 50);
        if (!sd_tx_req) check("tx_req_timeout", 32'(sd_tx_req), 32'd1);
    endtask

    task automatic wait_tx_acc(output logic [3:0] acc);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (cl_tx_acc == 4'b0 && n < 100);
        acc = cl_tx_acc;
        if (acc == 4'b0) check("tx_acc_timeout", 32'(cl_tx_acc), 32'hF);
        tick();
    endtask

    task automatic rx_send(input logic [7:0] b);
        int n = 0;
        sd_rx_req  = 1'b1;
        sd_rx_data = b;
        do begin
            @(negedge clk);
            n++;
        end while (!sd_rx_gnt && n < 50);
        if (!sd_rx_gnt) check("rx_gnt_timeout", 32'(sd_rx_gnt), 32'd1);
        tick();
        sd_rx_req = 1'b0;
    endtask

    task automatic wait_rx_empty();
        int n = 0;
        do begin
            tick();
            n++;
        end while (rxr_exp.size() != 0 && n < 50);
        check("rx_drain", 32'(rxr_exp.size()), 32'd0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] acc;
        rst_n      = 1'b0;
        cl_tx_data = '0;
        cl_tx_req  = '0;
        cl_rx_acc  = 4'hF;
        sd_tx_gnt  = 1'b1;
        sd_rx_req  = 1'b0;
        sd_rx_data = '0;
        fork
            monitor();
        join_none

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst_n = 1'b1;
        tick();

        // Single frame from client 2
        tx_exp.push_back(8'h82); tx_exp.push_back(8'h5A); acc_exp.push_back(4'b0100);
        cl_tx_data[23:16] = 8'h5A;
        cl_tx_req         = 4'b0100;
        wait_tx_req();
        check("t1_hdr", 32'(sd_tx_data), 32'h82);
        @(negedge clk);
        check("t1_pay_req", 32'(sd_tx_req), 32'd1);
        check("t1_pay", 32'(sd_tx_data), 32'h5A);
        @(negedge clk);
        check("t1_acc", 32'(cl_tx_acc), 32'b0100);
        check("t1_done_req", 32'(sd_tx_req), 32'd0);
        tick();
        cl_tx_req = 4'b0;
        repeat (3) tick();

        // All four clients from reset, client 0 re-requests after its first frame
        apply_reset();
        cl_tx_data = 32'h13121110;
        tx_exp.push_back(8'h80); tx_exp.push_back(8'h10);
        tx_exp.push_back(8'h81); tx_exp.push_back(8'h11);
        tx_exp.push_back(8'h82); tx_exp.push_back(8'h12);
        tx_exp.push_back(8'h83); tx_exp.push_back(8'h13);
        tx_exp.push_back(8'h80); tx_exp.push_back(8'h20);
        acc_exp.push_back(4'b0001); acc_exp.push_back(4'b0010);
        acc_exp.push_back(4'b0100); acc_exp.push_back(4'b1000);
        acc_exp.push_back(4'b0001);
        cl_tx_req = 4'hF;
        for (int i = 0; i < 5; i++) begin
            wait_tx_acc(acc);
            cl_tx_req = cl_tx_req & ~acc;
            if (i == 0) begin
                cl_tx_data[7:0] = 8'h20;
                cl_tx_req[0]    = 1'b1;
            end
        end
        check("t2_tx_drain", 32'(tx_exp.size()), 32'd0);

        // Serdes stalls 10 cycles on the header
        sd_tx_gnt = 1'b0;
        cl_tx_data[15:8] = 8'h77;
        tx_exp.push_back(8'h81); tx_exp.push_back(8'h77); acc_exp.push_back(4'b0010);
        cl_tx_req = 4'b0010;
        wait_tx_req();
        for (int k = 0; k < 10; k++) begin
            check("t3_hold_req", 32'(sd_tx_req), 32'd1);
            check("t3_hold_data", 32'(sd_tx_data), 32'h81);
            if (k < 9) @(negedge clk);
        end
        tick();
        sd_tx_gnt = 1'b1;
        wait_tx_acc(acc);
        cl_tx_req = cl_tx_req & ~acc;

        // RX to client 1 with delayed accept; other clients' accepts ignored
        cl_rx_acc = 4'b1101;
        rxr_exp.push_back(4'b0010); rxd_exp.push_back(8'h3C);
        rx_send(8'h81);
        rx_send(8'h3C);
        sd_rx_req  = 1'b1;
        sd_rx_data = 8'h82;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t4_rx_req_hold", 32'(cl_rx_req), 32'b0010);
            check("t4_rx_data_hold", cl_rx_data, {4{8'h3C}});
            check("t4_rx_backpressure", 32'(sd_rx_gnt), 32'd0);
        end
        tick();
        cl_rx_acc = 4'b0010;
        tick();
        cl_rx_acc = 4'hF;
        @(negedge clk);
        check("t4_rx_req_cleared", 32'(cl_rx_req), 32'd0);
        check("t4_rx_resume_gnt", 32'(sd_rx_gnt), 32'd1);
        tick();
        rxr_exp.push_back(4'b0100); rxd_exp.push_back(8'h44);
        rx_send(8'h44);
        wait_rx_empty();

        // Bad headers then a good frame to client 0
        err_seen = 0;
        rxr_exp.push_back(4'b0001); rxd_exp.push_back(8'h11);
        rx_send(8'h05);
        rx_send(8'h84);
        rx_send(8'h80);
        rx_send(8'h11);
        wait_rx_empty();
        check("t5_err_pulses", 32'(err_seen), 32'd2);
        check("t5_err_cnt", 32'(err_cnt), 32'd2);

        // Counter saturation
        for (int k = 0; k < 253; k++) rx_send(8'h40);
        check("t5_err_cnt_full", 32'(err_cnt), 32'hFF);
        rx_send(8'hC1);
        tick();
        check("t5_err_cnt_sat", 32'(err_cnt), 32'hFF);
        check("t5_err_pulses_all", 32'(err_seen), 32'd256);

        // Reset while TX is in payload and RX is delivering
        cl_rx_acc = 4'b0;
        rx_send(8'h83);
        rx_send(8'h99);
        sd_tx_gnt = 1'b0;
        tx_exp.push_back(8'h82);
        cl_tx_data[23:16] = 8'hAB;
        cl_tx_req = 4'b0100;
        wait_tx_req();
        tick();
        sd_tx_gnt = 1'b1;
        tick();
        sd_tx_gnt = 1'b0;
        @(negedge clk);
        check("t6_pre_tx_pay", 32'(sd_tx_data), 32'hAB);
        check("t6_pre_rx_dlv", 32'(cl_rx_req), 32'b1000);
        tick();
        rst_n = 1'b0;
        #1;
        check_outputs_zero("t6_async_rst");
        cl_tx_req = 4'b0;
        cl_rx_acc = 4'hF;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        sd_tx_gnt = 1'b1;
        tick();
        tx_exp.push_back(8'h81); tx_exp.push_back(8'h66); acc_exp.push_back(4'b0010);
        cl_tx_data[15:8] = 8'h66;
        cl_tx_req = 4'b0010;
        wait_tx_acc(acc);
        cl_tx_req = cl_tx_req & ~acc;
        repeat (3) tick();
        rxr_exp.push_back(4'b0001); rxd_exp.push_back(8'h5E);
        rx_send(8'h80);
        rx_send(8'h5E);
        wait_rx_empty();

        check("end_tx_drain", 32'(tx_exp.size()), 32'd0);
        check("end_acc_drain", 32'(acc_exp.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/byte_link_arbiter.md
Name: byte_link_arbiter

Overview:
- Shares one serdes parallel port between N_CLIENTS byte clients.
- Each TX byte from a client goes out as a 2-byte frame: header byte (carries client ID), then payload byte.
- RX frames are decoded and the payload is delivered to the client addressed by the header.
- Sits between the client Byte ports (arbiter side) and the serdes parallel port (client side). TX and RX paths run independently and concurrently.

Parameters:
- N_CLIENTS, 4, number of clients (2..8).
- ID_W, $clog2(N_CLIENTS), client ID width (derived; do not override).
- ERR_W, 8, width of the saturating header-error counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cl_tx_data  in  N_CLIENTS*8  client TX bytes; client i uses bits [8i+7:8i]
- cl_tx_req  in  N_CLIENTS  client TX requests
- cl_tx_acc  out  N_CLIENTS  one-cycle TX accept pulse per client
- cl_rx_data  out  N_CLIENTS*8  RX payload, same value driven to every client
- cl_rx_req  out  N_CLIENTS  RX valid, one-hot
- cl_rx_acc  in  N_CLIENTS  client RX accept
- sd_tx_req  out  1  byte valid to serdes
- sd_tx_data  out  8  byte to serdes
- sd_tx_gnt  in  1  serdes consumed byte this cycle
- sd_rx_req  in  1  serdes has RX byte
- sd_rx_data  in  8  RX byte
- sd_rx_gnt  out  1  arbiter consumes RX byte this cycle
- err_hdr  out  1  one-cycle pulse on bad RX header
- err_cnt  out  ERR_W  saturating count of bad headers

Behaviour:
- Reset: async on rst_n low.
  - All outputs 0.
  - Both FSMs to idle states.
  - RR pointer = 0; payload/ID registers = 0.
  - Any in-flight frame is abandoned; no partial tx_acc.
- Header format: bit7 = 1; bits[ID_W-1:0] = ID; all other bits 0.
- TX FSM: TX_IDLE -> TX_HDR -> TX_PAY -> TX_DONE -> TX_IDLE.
  - TX_IDLE: if any cl_tx_req is set, grant the first requester at or after the RR pointer (wrapping). Latch the grant ID and that client's data, then go to TX_HDR.
  - TX_HDR: sd_tx_req=1, sd_tx_data=header. On sd_tx_gnt, go to TX_PAY.
  - TX_PAY: sd_tx_req=1, sd_tx_data=latched payload. On sd_tx_gnt, go to TX_DONE.
  - TX_DONE: cl_tx_acc[id]=1 for exactly one cycle; RR pointer = (id+1) mod N_CLIENTS; go to TX_IDLE.
  - sd_tx_data is stable while sd_tx_req=1 and gnt=0.
  - A client deasserting cl_tx_req after grant does not abort the frame.
  - Minimum 4 cycles per frame with gnt tied high.
  - Client must hold req/data until cl_tx_acc and drop req on the acc edge.
- RX FSM: RX_HDR -> RX_PAY -> RX_DLV -> RX_HDR.
  - sd_rx_gnt = sd_rx_req, combinationally, in RX_HDR and RX_PAY; 0 in RX_DLV (backpressure).
  - RX_HDR, byte consumed:
    - Valid header (bit7=1, ID<N_CLIENTS, other bits 0): latch ID, go to RX_PAY.
    - Otherwise: byte dropped, err_hdr pulses next cycle, err_cnt +1 (saturates at all-ones), stay in RX_HDR.
  - RX_PAY, byte consumed: latch payload, go to RX_DLV.
  - RX_DLV: cl_rx_req[id]=1, cl_rx_data=payload, held until cl_rx_acc[id]; then go to RX_HDR with cl_rx_req cleared the next cycle.
  - cl_rx_acc on non-addressed clients is ignored.
- Simultaneous events:
  - TX and RX transfers in the same cycle are independent.
  - Client requesting in TX_DONE is considered in the next TX_IDLE cycle.

Decomposition:
- Shared package transporter_pkg holds:
  - tx_state_t and rx_state_t enums.
  - HDR_MARK constant (bit 7).
  - Functions make_hdr(id) and hdr_valid(byte, n).
- One sub-module, rr_arbiter: parameterised N; inputs req vector, pointer; output one-hot grant + binary ID; purely combinational. Reused by future multi-link schedulers.

Test Plan:
- Client 2 sends 0x5A, sd_tx_gnt tied 1 -> sd_tx_data 0x82 then 0x5A on consecutive sd_tx_req cycles; cl_tx_acc[2] single pulse; no other acc.
- All 4 clients request from reset with data 0x10..0x13 -> headers 0x80,0x81,0x82,0x83 in that order, each followed by its payload; repeat request from client 0 served after client 3.
- sd_tx_gnt held low 10 cycles in TX_HDR -> sd_tx_req and sd_tx_data=0x81 stable all 10 cycles; progresses on first gnt.
- RX 0x81,0x3C, cl_rx_acc[1] delayed 5 cycles -> cl_rx_req=4'b0010, cl_rx_data=0x3C stable; sd_rx_gnt=0 while next byte is pending; resumes after acc.
- RX 0x05, then 0x84 (N=4), then 0x80,0x11 -> two err_hdr pulses, err_cnt=2, client 0 receives 0x11. Separately force 255 errors, then one more -> err_cnt stays 0xFF.
- rst_n low for 1 cycle during TX_PAY and RX_DLV -> all outputs 0 immediately; after release, a new frame from client 1 completes normally with no stale tx_acc.
